alu_result_buffer: RTL and testbench

- Downstream consumer of the 7-bit ALU datapath. Accepts one ALU result per valid cycle into a small FIFO and presents results to a downstream reader over a valid/ready handshake.
- Keeps running statistics beside the FIFO: total results, non-zero results and the maximum result seen.
- Lets the controller FSM run ahead of a slow consumer without losing results, and reports drops when the FIFO is full.

---
 rtl/alu_pkg.sv | 14 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/alu_result_buffer.sv | 108 ++++++++++
 tb/tb_alu_result_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode constants and the buffered-entry layout.
package alu_pkg;

  localparam int unsigned ALU_W = 7;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic             zf;
    logic [ALU_W-1:0] result;
  } alu_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, wrapping pointers and an occupancy counter.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       wdata_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] fill_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned FillW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             do_push, do_pop;

  assign full_o  = (fill_q == FillW'(Depth));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Stale storage is masked so an empty FIFO always presents zero.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results for a valid/ready reader and keeps saturating result statistics.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_result,
  input  logic                   in_zf,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_nonzero,
  input  logic                   out_ready,
  input  logic                   clear_stats,
  output logic [CNT_W-1:0]       total_cnt,
  output logic [CNT_W-1:0]       nonzero_cnt,
  output logic [WIDTH-1:0]       max_result,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] fill
);

  logic             push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [WIDTH:0]   wr_entry, rd_entry;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] nonzero_q, nonzero_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [WIDTH-1:0] max_q, max_d;

  assign in_ready  = ~fifo_full | out_ready;
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign drop      = in_valid & ~in_ready;

  assign wr_entry    = {in_zf, in_result};
  assign out_data    = rd_entry[WIDTH-1:0];
  assign out_nonzero = out_valid & ~rd_entry[WIDTH];

  sync_fifo #(
    .Width (WIDTH + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  // Clear takes priority over any same-cycle push or drop.
  always_comb begin
    total_d   = total_q;
    nonzero_d = nonzero_q;
    drop_d    = drop_q;
    max_d     = max_q;
    if (clear_stats) begin
      total_d   = '0;
      nonzero_d = '0;
      drop_d    = '0;
      max_d     = '0;
    end else begin
      if (push) begin
        if (total_q != '1) begin
          total_d = total_q + CNT_W'(1);
        end
        if (!in_zf && nonzero_q != '1) begin
          nonzero_d = nonzero_q + CNT_W'(1);
        end
        if (in_result > max_q) begin
          max_d = in_result;
        end
      end
      if (drop && drop_q != '1) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_q   <= '0;
      nonzero_q <= '0;
      drop_q    <= '0;
      max_q     <= '0;
    end else begin
      total_q   <= total_d;
      nonzero_q <= nonzero_d;
      drop_q    <= drop_d;
      max_q     <= max_d;
    end
  end

  assign total_cnt   = total_q;
  assign nonzero_cnt = nonzero_q;
  assign drop_cnt    = drop_q;
  assign max_result  = max_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: queue-based reference model plus an output monitor.
module tb_alu_result_buffer;

  localparam int WIDTH   = 7;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic [WIDTH-1:0]       in_result = '0;
  logic                   in_zf = 1'b0;
  logic                   out_ready = 1'b0;
  logic                   clear_stats = 1'b0;
  logic                   in_ready, out_valid, out_nonzero;
  logic [WIDTH-1:0]       out_data, max_result;
  logic [CNT_W-1:0]       total_cnt, nonzero_cnt, drop_cnt;
  logic [$clog2(DEPTH):0] fill;

  alu_result_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_result   (in_result),
    .in_zf       (in_zf),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_nonzero (out_nonzero),
    .out_ready   (out_ready),
    .clear_stats (clear_stats),
    .total_cnt   (total_cnt),
    .nonzero_cnt (nonzero_cnt),
    .max_result  (max_result),
    .drop_cnt    (drop_cnt),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit zf;
    int r;
  } ent_t;

  ent_t sb_q[$];
  int   m_cnt, m_total, m_nz, m_max, m_drop;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit v, input int r, input bit zf, input bit ordy,
                       input bit clr, input bit rst);
    bit rdy_e, push_e, pop_e;
    ent_t e;
    in_valid    = v;
    in_result   = WIDTH'(r);
    in_zf       = zf;
    out_ready   = ordy;
    clear_stats = clr;
    reset       = rst;
    #1;
    rdy_e = (m_cnt != DEPTH) || ordy;
    chk("in_ready", int'(in_ready), int'(rdy_e));
    if (rst) begin
      m_cnt = 0; m_total = 0; m_nz = 0; m_max = 0; m_drop = 0;
      sb_q.delete();
    end else begin
      push_e = v && rdy_e;
      pop_e  = (m_cnt > 0) && ordy;
      if (push_e) begin
        e.zf = zf;
        e.r  = r;
        sb_q.push_back(e);
      end
      m_cnt = m_cnt + int'(push_e) - int'(pop_e);
      if (clr) begin
        m_total = 0; m_nz = 0; m_max = 0; m_drop = 0;
      end else begin
        if (push_e) begin
          m_total = sat_inc(m_total);
          if (!zf) m_nz = sat_inc(m_nz);
          if (r > m_max) m_max = r;
        end
        if (v && !rdy_e) m_drop = sat_inc(m_drop);
      end
    end
    @(posedge clk);
    #1;
    chk("fill", int'(fill), m_cnt);
    chk("out_valid", int'(out_valid), int'(m_cnt != 0));
    chk("total_cnt", int'(total_cnt), m_total);
    chk("nonzero_cnt", int'(nonzero_cnt), m_nz);
    chk("max_result", int'(max_result), m_max);
    chk("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // Monitor: head must match the scoreboard front; a pop retires it.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_unexpected actual %0d required none at %0t", out_data, $time);
        end else begin
          e = sb_q[0];
          chk("head_data", int'(out_data), e.r);
          chk("head_nonzero", int'(out_nonzero), int'(!e.zf));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int r;
    @(posedge clk);
    #1;
    m_cnt = 0; m_total = 0; m_nz = 0; m_max = 0; m_drop = 0;
    chk("rst_fill", int'(fill), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_nonzero", int'(out_nonzero), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_total", int'(total_cnt), 0);
    chk("rst_max", int'(max_result), 0);

    cycle(1, 5, 0, 0, 0, 0);
    chk("first_data", int'(out_data), 5);
    chk("first_nonzero", int'(out_nonzero), 1);
    cycle(0, 0, 0, 1, 0, 0);

    cycle(1, 3, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 9, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0);
    chk("full_fill", int'(fill), 4);
    cycle(1, 7, 0, 0, 0, 0);
    chk("drop_one", int'(drop_cnt), 1);
    chk("total_five", int'(total_cnt), 5);
    chk("nonzero_four", int'(nonzero_cnt), 4);
    chk("max_nine", int'(max_result), 9);

    cycle(1, 11, 0, 1, 0, 0);
    chk("passthru_fill", int'(fill), 4);
    chk("passthru_head", int'(out_data), 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);

    cycle(1, 127, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    chk("max_127", int'(max_result), 127);
    for (int i = 0; i < 300; i++) cycle(1, (i % 100) + 1, 0, 1, 0, 0);
    chk("total_sat", int'(total_cnt), 255);
    chk("max_kept", int'(max_result), 127);

    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 20, 0, 0, 0, 0);
    cycle(1, 21, 0, 0, 0, 0);
    cycle(1, 6, 0, 0, 1, 0);
    chk("clr_total", int'(total_cnt), 0);
    chk("clr_fill", int'(fill), 3);
    chk("clr_head", int'(out_data), 20);

    cycle(0, 0, 0, 0, 0, 1);
    chk("midrst_fill", int'(fill), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    cycle(1, 4, 0, 0, 0, 0);
    chk("after_rst_data", int'(out_data), 4);
    cycle(0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
      cycle($urandom_range(0, 3) != 0, r,
            ($urandom_range(0, 9) == 0) ? bit'($urandom_range(0, 1)) : (r == 0),
            $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("drained_fill", int'(fill), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
